// File: rtl/apb_requester.sv
// apb_requester: single-outstanding bridge from a valid/ready command stream to APB transfers
// Optional feature: define APB_REQ_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES
// cycles of pready low; otherwise ACCESS waits indefinitely and rsp_timeout is tied to 0.
// Ports: clk, reset (asynchronous, active-low);
//        cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata - command stream;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout - response stream;
//        psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr - APB requester pins.
module apb_requester #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic done, tmo, cap;
    logic cmd_ready_nx, psel_nx, penable_nx, rsp_valid_nx, pwrite_nx, rsp_err_nx;
    logic [ADDR_W-1:0] paddr_nx;
    logic [DATA_W-1:0] pwdata_nx, rsp_rdata_nx;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign done = state == ACCESS && pready;
    assign cap  = state == IDLE && cmd_valid;

`ifdef APB_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    logic             rsp_timeout_q;
    // cnt holds the number of low-pready ACCESS cycles already seen, so the
    // abort fires during the TIMEOUT_CYCLES-th one unless pready rises in it.
    assign tmo         = state == ACCESS && !pready && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign rsp_timeout = rsp_timeout_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt           <= state == SETUP ? '0 : state == ACCESS && !pready ? cnt + CNT_W'(1) : cnt;
            rsp_timeout_q <= done ? 1'b0 : tmo ? 1'b1 : rsp_timeout_q;
        end
    end
`else
    assign tmo         = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   state_nx = cmd_valid ? SETUP : IDLE;
            SETUP:  state_nx = ACCESS;
            ACCESS: state_nx = done || tmo ? RESP : ACCESS;
            RESP:   state_nx = rsp_ready ? IDLE : RESP;
        endcase
    end

    // Outputs are registered, so their next values are decoded from state_nx.
    always_comb begin
        cmd_ready_nx = state_nx == IDLE;
        psel_nx      = state_nx == SETUP || state_nx == ACCESS;
        penable_nx   = state_nx == ACCESS;
        rsp_valid_nx = state_nx == RESP;
        pwrite_nx    = cap ? cmd_write : pwrite;
        paddr_nx     = cap ? cmd_addr : paddr;
        pwdata_nx    = cap ? (cmd_write ? cmd_wdata : '0) : pwdata;
        rsp_rdata_nx = done ? (pwrite ? '0 : prdata) : tmo ? '0 : rsp_rdata;
        rsp_err_nx   = done ? pslverr : tmo || rsp_err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            cmd_ready <= cmd_ready_nx;
            psel      <= psel_nx;
            penable   <= penable_nx;
            rsp_valid <= rsp_valid_nx;
            pwrite    <= pwrite_nx;
            paddr     <= paddr_nx;
            pwdata    <= pwdata_nx;
            rsp_rdata <= rsp_rdata_nx;
            rsp_err   <= rsp_err_nx;
        end
    end
endmodule
